// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg
//   Shared helpers for the pipelined adder:
//     chunk_width  - bits handled by each pipeline stage (WIDTH / STAGES)
//     params_legal - WIDTH/STAGES legality, used for an elaboration check
//     full_add     - one full-adder cell, returns {carry, sum}
package pipelined_adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : 1;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// adder_slice
//   CHUNK-bit ripple-carry adder built from full-adder cells. One instance
//   per pipeline stage.
//   Ports:
//     a, b  in  CHUNK  operand chunks
//     cin   in  1      carry into bit 0
//     sum   out CHUNK  chunk sum
//     cout  out 1      carry out of the top bit
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
    end

    assign cout = carry[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Add/subtract split into STAGES chunk-wide stages. Stage k adds operand
//   chunk k (LSB chunk first) with the registered carry of stage k-1. The
//   untouched upper operand chunks travel forward in skew registers and the
//   finished lower sum chunks travel forward in de-skew registers, so sum,
//   cout and ovf all leave the last stage together, STAGES cycles after
//   acceptance.
//
//   Handshake: an input is accepted on a rising edge where in_valid && in_ready;
//   a result is consumed on a rising edge where out_valid && out_ready.
//   stall = out_valid && !out_ready freezes every register (data and valid
//   bits) and drops in_ready; with out_valid=0 out_ready is ignored, so a
//   bubble at the output never blocks the pipe.
//
//   Ports:
//     clk, rst         clock, asynchronous active-high reset
//     in_valid/in_ready input handshake
//     a, b             operands (WIDTH)
//     cin              carry-in, add only
//     sub              0 = a + b + cin, 1 = a - b
//     out_valid/out_ready output handshake
//     sum, cout, ovf   result, carry-out (no-borrow on sub), signed overflow
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if (!params_legal(WIDTH, STAGES)) begin : g_illegal
        $error("pipelined_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    // Stage registers (index = stage that produced them)
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             ovf_q;

    // Stage inputs and next-state values
    logic             st_v  [STAGES];
    logic [WIDTH-1:0] st_a  [STAGES];
    logic [WIDTH-1:0] st_b  [STAGES];
    logic [WIDTH-1:0] st_s  [STAGES];
    logic             st_c  [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];

    logic stall;

    assign stall    = v_q[LAST] && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] chunk_sum;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1: invert b here and force carry-in.
            assign st_v[k] = in_valid;
            assign st_a[k] = a;
            assign st_b[k] = sub ? ~b : b;
            assign st_s[k] = '0;
            assign st_c[k] = sub | cin;
        end else begin : g_next
            assign st_v[k] = v_q[k-1];
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_s[k] = s_q[k-1];
            assign st_c[k] = c_q[k-1];
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a    (st_a[k][k*CHUNK +: CHUNK]),
            .b    (st_b[k][k*CHUNK +: CHUNK]),
            .cin  (st_c[k]),
            .sum  (chunk_sum),
            .cout (nxt_c[k])
        );

        // Sum bits at chunk k and above are still zero on entry, so the new
        // chunk can simply be OR-ed into place.
        assign nxt_s[k] = st_s[k] | (WIDTH'(chunk_sum) << (k * CHUNK));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= st_v[k];
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                s_q[k] <= nxt_s[k];
                c_q[k] <= nxt_c[k];
            end
            // Overflow: effective operands agree in sign but the sum does not.
            ovf_q <= (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                     (nxt_s[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Main DUT: WIDTH=8, STAGES=2
    // ------------------------------------------------------------------
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    pipelined_adder #(
        .WIDTH  (8),
        .STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // ------------------------------------------------------------------
    // WIDTH=4 DUTs for STAGES = 1, 2, 4 (index 0, 1, 2)
    // ------------------------------------------------------------------
    logic       x_in_valid  [3];
    logic       x_in_ready  [3];
    logic [3:0] x_a         [3];
    logic [3:0] x_b         [3];
    logic       x_cin       [3];
    logic       x_sub       [3];
    logic       x_out_valid [3];
    logic       x_out_ready [3];
    logic [3:0] x_sum       [3];
    logic       x_cout      [3];
    logic       x_ovf       [3];

    pipelined_adder #(.WIDTH(4), .STAGES(1)) dut_w4_s1 (
        .clk(clk), .rst(rst),
        .in_valid(x_in_valid[0]), .in_ready(x_in_ready[0]),
        .a(x_a[0]), .b(x_b[0]), .cin(x_cin[0]), .sub(x_sub[0]),
        .out_valid(x_out_valid[0]), .out_ready(x_out_ready[0]),
        .sum(x_sum[0]), .cout(x_cout[0]), .ovf(x_ovf[0])
    );

    pipelined_adder #(.WIDTH(4), .STAGES(2)) dut_w4_s2 (
        .clk(clk), .rst(rst),
        .in_valid(x_in_valid[1]), .in_ready(x_in_ready[1]),
        .a(x_a[1]), .b(x_b[1]), .cin(x_cin[1]), .sub(x_sub[1]),
        .out_valid(x_out_valid[1]), .out_ready(x_out_ready[1]),
        .sum(x_sum[1]), .cout(x_cout[1]), .ovf(x_ovf[1])
    );

    pipelined_adder #(.WIDTH(4), .STAGES(4)) dut_w4_s4 (
        .clk(clk), .rst(rst),
        .in_valid(x_in_valid[2]), .in_ready(x_in_ready[2]),
        .a(x_a[2]), .b(x_b[2]), .cin(x_cin[2]), .sub(x_sub[2]),
        .out_valid(x_out_valid[2]), .out_ready(x_out_ready[2]),
        .sum(x_sum[2]), .cout(x_cout[2]), .ovf(x_ovf[2])
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  exp_q  [$];   // {ovf, cout, sum} for the 8-bit DUT
    logic [5:0]  exp4_q [$];   // {ovf, cout, sum} for the 4-bit DUTs

    // Reference for the 4-bit DUTs, straight from the arithmetic definition.
    function automatic logic [5:0] ref4(input logic [3:0] ra, input logic [3:0] rb,
                                        input logic rc, input logic rs);
        logic [3:0] eb;
        logic [4:0] full;
        logic       o;
        eb   = rs ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, eb} + {4'b0000, (rs ? 1'b1 : rc)};
        o    = (ra[3] == eb[3]) && (full[3] != ra[3]);
        return {o, full};
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, ovf, cout, sum, in_ready} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got out_valid=%b ovf=%b cout=%b sum=%h in_ready=%b exp 0 0 0 00 1",
                     out_valid, ovf, cout, sum, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] la   [7] = '{8'h0F, 8'h7F, 8'hFF, 8'h00, 8'h80, 8'h0F, 8'h05};
        logic [7:0] lb   [7] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'hF0, 8'h03};
        logic       lcin [7] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        logic       lsub [7] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [9:0] lexp [7] = '{10'h010, 10'h280, 10'h100, 10'h0FF, 10'h37F, 10'h100, 10'h102};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a = la[i]; b = lb[i]; cin = lcin[i]; sub = lsub[i];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_in_ready[%0d] got %b exp 1", i, in_ready);
            end
            // After the accepting edge: nothing out yet, and out_ready=0 with
            // an empty output slot must not stall.
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL directed_early[%0d] got out_valid=%b in_ready=%b exp 0 1",
                         i, out_valid, in_ready);
            end
            out_ready = 1'b1;
            @(negedge clk);
            #1;
            checks++;
            if ({out_valid, ovf, cout, sum} !== {1'b1, lexp[i]}) begin
                errors++;
                $display("FAIL directed_result[%0d] got v=%b ovf=%b cout=%b sum=%h exp v=1 %h",
                         i, out_valid, ovf, cout, sum, lexp[i]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_bubble[%0d] got out_valid=%b exp 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta   [4] = '{8'h01, 8'h10, 8'hFF, 8'h10};
        logic [7:0] tb   [4] = '{8'h02, 8'h20, 8'hFF, 8'h20};
        logic       tcin [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
        logic       tsub [4] = '{1'b0,  1'b0,  1'b0,  1'b1};
        logic [9:0] texp [4] = '{10'h003, 10'h030, 10'h1FF, 10'h0F0};
        int         sent = 0;
        int         got = 0;
        int         stall_left = 3;
        bit         seen = 1'b0;
        logic [9:0] held = '0;
        logic [9:0] expv;
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            if (sent < 4) begin
                in_valid = 1'b1;
                a = ta[sent]; b = tb[sent]; cin = tcin[sent]; sub = tsub[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                held = {ovf, cout, sum};
            end
            out_ready = (seen && stall_left > 0) ? 1'b0 : 1'b1;
            #1;
            if (!out_ready) begin
                checks++;
                if ({in_ready, out_valid, ovf, cout, sum} !== {1'b0, 1'b1, held}) begin
                    errors++;
                    $display("FAIL b2b_stall got in_ready=%b v=%b out=%h exp in_ready=0 v=1 out=%h",
                             in_ready, out_valid, {ovf, cout, sum}, held);
                end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got out=%h exp no result", {ovf, cout, sum});
                end else begin
                    expv = exp_q.pop_front();
                    if ({ovf, cout, sum} !== expv) begin
                        errors++;
                        $display("FAIL b2b_result[%0d] got %h exp %h", got, {ovf, cout, sum}, expv);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(texp[sent]);
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 4 || sent != 4 || exp_q.size() != 0 || stall_left != 0) begin
            errors++;
            $display("FAIL b2b_count got sent=%0d got=%0d left=%0d stall_left=%0d exp 4 4 0 0",
                     sent, got, exp_q.size(), stall_left);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_duplicate got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 8'h01; b = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, ovf, cout, sum} !== {1'b1, 10'h046}) begin
            errors++;
            $display("FAIL rstmid_inflight got v=%b out=%h exp v=1 046",
                     out_valid, {ovf, cout, sum});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, ovf, cout, sum, in_ready} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_clear got v=%b ovf=%b cout=%b sum=%h in_ready=%b exp 0 0 0 00 1",
                     out_valid, ovf, cout, sum, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        a = 8'h7F; b = 8'h7F; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_release got in_ready=%b v=%b exp 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale got out_valid=%b exp 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, ovf, cout, sum} !== {1'b1, 10'h2FE}) begin
            errors++;
            $display("FAIL rstmid_next got v=%b out=%h exp v=1 2FE", out_valid, {ovf, cout, sum});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet[%0d] got out_valid=%b exp 0", i, out_valid);
            end
        end
    endtask

    task automatic test_exhaustive(input int cfg);
        int         n = 0;
        int         got = 0;
        int         cyc = 0;
        logic [9:0] nv;
        logic [5:0] obs;
        logic [5:0] expv;
        exp4_q.delete();
        while ((n < 1024 || got < 1024) && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            nv = 10'(n);
            x_in_valid[cfg]  = (n < 1024);
            x_a[cfg]         = nv[3:0];
            x_b[cfg]         = nv[7:4];
            x_cin[cfg]       = nv[8];
            x_sub[cfg]       = nv[9];
            x_out_ready[cfg] = ($urandom_range(0, 3) != 0);
            #1;
            if (x_out_valid[cfg] && x_out_ready[cfg]) begin
                obs = {x_ovf[cfg], x_cout[cfg], x_sum[cfg]};
                checks++;
                if (exp4_q.size() == 0) begin
                    errors++;
                    $display("FAIL exh_cfg%0d_extra got %h exp no result", cfg, obs);
                end else begin
                    expv = exp4_q.pop_front();
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL exh_cfg%0d_result[%0d] got %h exp %h", cfg, got, obs, expv);
                    end
                end
                got++;
            end
            if (x_in_valid[cfg] && x_in_ready[cfg]) begin
                exp4_q.push_back(ref4(x_a[cfg], x_b[cfg], x_cin[cfg], x_sub[cfg]));
                n++;
            end
        end
        x_in_valid[cfg]  = 1'b0;
        x_out_ready[cfg] = 1'b1;
        checks++;
        if (n != 1024 || got != 1024 || exp4_q.size() != 0) begin
            errors++;
            $display("FAIL exh_cfg%0d_count got sent=%0d got=%0d left=%0d exp 1024 1024 0",
                     cfg, n, got, exp4_q.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x_in_valid[i] = 1'b0; x_a[i] = '0; x_b[i] = '0;
            x_cin[i] = 1'b0; x_sub[i] = 1'b0; x_out_ready[i] = 1'b1;
        end

        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        for (int cfg = 0; cfg < 3; cfg++) begin
            test_exhaustive(cfg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
